// File: rtl/pulse_meas_pkg.sv
// rtl/pulse_meas_pkg.sv - shared types and helpers for the pulse width meter
package pulse_meas_pkg;

   typedef enum logic [1:0] {
      SETTLE,
      WAIT_INACT,
      IDLE,
      MEASURE
   } meas_state_t;

   function automatic logic [31:0] sat_max(input int w);
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - multi-flop synchronizer for a single asynchronous bit
module bit_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         chain <= {STAGES{RST_VAL}};
      else
         chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/pulse_width_meter.sv
// rtl/pulse_width_meter.sv - measures active pulse width on an async input, one-deep result buffer
module pulse_width_meter
   import pulse_meas_pkg::*;
#(
   parameter int W           = 8,
   parameter int SYNC_STAGES = 2,
   parameter int MIN_WIDTH   = 1,
   parameter bit ACTIVE_HIGH = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr_lost,
   input  logic         sig_in,
   output logic [W-1:0] width,
   output logic         ovf,
   output logic         valid,
   input  logic         ready,
   output logic         lost,
   output logic         busy
);

   localparam logic [W-1:0] CNT_MAX     = W'(sat_max(W));
   localparam logic [W-1:0] SETTLE_LAST = W'(SYNC_STAGES - 1);
   localparam logic [W-1:0] MIN_CNT     = W'(MIN_WIDTH);

   meas_state_t  state, state_nxt;
   logic [W-1:0] count, count_nxt;
   logic         sat, sat_nxt;
   logic         fin;
   logic         raw;
   logic         s;

   // Polarity is folded in ahead of the synchronizer so the chain always idles at 0
   assign raw = ACTIVE_HIGH ? sig_in : ~sig_in;

   bit_sync #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b0)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (raw),
      .q   (s)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= SETTLE;
         count <= '0;
         sat   <= 1'b0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         sat   <= sat_nxt;
      end
   end

   // count doubles as the settle timer; it is reloaded on leaving SETTLE and IDLE
   always_comb begin
      state_nxt = state;
      count_nxt = count;
      sat_nxt   = sat;
      fin       = 1'b0;
      if (!en) begin
         state_nxt = SETTLE;
         count_nxt = '0;
         sat_nxt   = 1'b0;
      end else begin
         case (state)
            SETTLE: begin
               if (count == SETTLE_LAST) begin
                  state_nxt = WAIT_INACT;
                  count_nxt = '0;
               end else begin
                  count_nxt = count + W'(1);
               end
            end
            WAIT_INACT: begin
               if (!s)
                  state_nxt = IDLE;
            end
            IDLE: begin
               if (s) begin
                  state_nxt = MEASURE;
                  count_nxt = W'(1);
                  sat_nxt   = 1'b0;
               end
            end
            MEASURE: begin
               if (s) begin
                  if (count == CNT_MAX)
                     sat_nxt = 1'b1;
                  else
                     count_nxt = count + W'(1);
               end else begin
                  state_nxt = IDLE;
                  fin       = 1'b1;
               end
            end
            default: state_nxt = SETTLE;
         endcase
      end
   end

   logic publish;
   logic accept;

   assign publish = fin && (count >= MIN_CNT);
   assign accept  = valid && ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         width <= '0;
         ovf   <= 1'b0;
         valid <= 1'b0;
         lost  <= 1'b0;
      end else begin
         if (publish && (!valid || ready)) begin
            width <= count;
            ovf   <= sat;
            valid <= 1'b1;
         end else if (accept) begin
            valid <= 1'b0;
         end
         // A drop on the same edge as clr_lost must leave lost set
         if (publish && valid && !ready)
            lost <= 1'b1;
         else if (clr_lost)
            lost <= 1'b0;
      end
   end

   assign busy = (state == MEASURE);

endmodule

// File: tb/tb_pulse_width_meter.sv
// tb/tb_pulse_width_meter.sv - directed self-checking bench for pulse_width_meter
module tb_pulse_width_meter;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       clr_lost;
   logic       sig_in;
   logic [7:0] width;
   logic       ovf;
   logic       valid;
   logic       ready;
   logic       lost;
   logic       busy;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   pulse_width_meter #(
      .W           (8),
      .SYNC_STAGES (2),
      .MIN_WIDTH   (3),
      .ACTIVE_HIGH (1'b1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .clr_lost (clr_lost),
      .sig_in   (sig_in),
      .width    (width),
      .ovf      (ovf),
      .valid    (valid),
      .ready    (ready),
      .lost     (lost),
      .busy     (busy)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // sig_in is sampled high at exactly n edges
   task automatic pulse(input int n);
      sig_in = 1'b1;
      tick(n);
      sig_in = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int k;
      k = 0;
      while (!valid && k < 20) begin
         tick(1);
         k++;
      end
      checks++;
      if (valid !== 1'b1) begin
         fails++;
         $display("FAIL %s: valid timeout, got %0b want 1", name, valid);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; en = 1'b1; clr_lost = 1'b0; sig_in = 1'b0; ready = 1'b0;
      tick(2);
      checks++;
      if ({width, ovf, valid, lost, busy} !== 12'h000) begin
         fails++;
         $display("FAIL reset_outputs: got w=%0d o=%0b v=%0b l=%0b b=%0b want all 0",
                  width, ovf, valid, lost, busy);
      end
      rst = 1'b0;
      tick(5);
   endtask

   task automatic test_basic;
      ready = 1'b1;
      pulse(5);
      tick(1);
      checks++;
      if (valid !== 1'b0) begin
         fails++; $display("FAIL basic_early1: valid got %0b want 0", valid);
      end
      tick(1);
      checks++;
      if (valid !== 1'b0) begin
         fails++; $display("FAIL basic_early2: valid got %0b want 0", valid);
      end
      tick(1);
      checks++;
      if (valid !== 1'b1 || width !== 8'd5 || ovf !== 1'b0) begin
         fails++;
         $display("FAIL basic_result: got v=%0b w=%0d o=%0b want v=1 w=5 o=0", valid, width, ovf);
      end
      tick(1);
      checks++;
      if (valid !== 1'b0) begin
         fails++; $display("FAIL basic_accept: valid got %0b want 0", valid);
      end
   endtask

   task automatic test_saturation;
      ready = 1'b0;
      pulse(300);
      wait_valid("sat_wait");
      checks++;
      if (width !== 8'd255 || ovf !== 1'b1) begin
         fails++; $display("FAIL sat_result: got w=%0d o=%0b want w=255 o=1", width, ovf);
      end
      ready = 1'b1; tick(1); ready = 1'b0;
      pulse(10);
      wait_valid("sat_next_wait");
      checks++;
      if (width !== 8'd10 || ovf !== 1'b0) begin
         fails++; $display("FAIL sat_next: got w=%0d o=%0b want w=10 o=0", width, ovf);
      end
      ready = 1'b1; tick(1); ready = 1'b0;
   endtask

   task automatic test_backpressure;
      ready = 1'b0;
      pulse(4);
      wait_valid("bp_first_wait");
      checks++;
      if (width !== 8'd4 || lost !== 1'b0) begin
         fails++; $display("FAIL bp_first: got w=%0d l=%0b want w=4 l=0", width, lost);
      end
      pulse(7);
      tick(4);
      checks++;
      if (valid !== 1'b1 || width !== 8'd4 || lost !== 1'b1) begin
         fails++;
         $display("FAIL bp_drop: got v=%0b w=%0d l=%0b want v=1 w=4 l=1", valid, width, lost);
      end
      ready = 1'b1; tick(1); ready = 1'b0;
      checks++;
      if (valid !== 1'b0 || lost !== 1'b1) begin
         fails++; $display("FAIL bp_accept: got v=%0b l=%0b want v=0 l=1", valid, lost);
      end
      clr_lost = 1'b1; tick(1); clr_lost = 1'b0;
      checks++;
      if (lost !== 1'b0) begin
         fails++; $display("FAIL bp_clr_lost: lost got %0b want 0", lost);
      end
   endtask

   task automatic test_same_edge;
      ready = 1'b0;
      pulse(4);
      wait_valid("same_first_wait");
      pulse(6);
      tick(2);
      checks++;
      if (valid !== 1'b1 || width !== 8'd4) begin
         fails++; $display("FAIL same_hold: got v=%0b w=%0d want v=1 w=4", valid, width);
      end
      ready = 1'b1;
      tick(1);
      checks++;
      if (valid !== 1'b1 || width !== 8'd6 || lost !== 1'b0) begin
         fails++;
         $display("FAIL same_edge: got v=%0b w=%0d l=%0b want v=1 w=6 l=0", valid, width, lost);
      end
      tick(1);
      ready = 1'b0;
      checks++;
      if (valid !== 1'b0) begin
         fails++; $display("FAIL same_drain: valid got %0b want 0", valid);
      end
   endtask

   task automatic test_glitch;
      ready = 1'b0;
      pulse(2);
      tick(6);
      checks++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL glitch_drop: got v=%0b b=%0b want v=0 b=0", valid, busy);
      end
      pulse(3);
      wait_valid("glitch_min_wait");
      checks++;
      if (width !== 8'd3) begin
         fails++; $display("FAIL glitch_min: width got %0d want 3", width);
      end
      ready = 1'b1; tick(1); ready = 1'b0;
   endtask

   task automatic test_startup;
      ready = 1'b0;
      sig_in = 1'b1;
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(10);
      checks++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL startup_held: got v=%0b b=%0b want v=0 b=0", valid, busy);
      end
      sig_in = 1'b0;
      tick(6);
      checks++;
      if (valid !== 1'b0) begin
         fails++; $display("FAIL startup_release: valid got %0b want 0", valid);
      end
      pulse(4);
      wait_valid("startup_wait");
      checks++;
      if (width !== 8'd4) begin
         fails++; $display("FAIL startup_fresh: width got %0d want 4", width);
      end
      ready = 1'b1; tick(1); ready = 1'b0;
   endtask

   task automatic test_abort;
      ready = 1'b0;
      sig_in = 1'b1;
      tick(10);
      checks++;
      if (busy !== 1'b1) begin
         fails++; $display("FAIL abort_busy: busy got %0b want 1", busy);
      end
      en = 1'b0;
      tick(1);
      checks++;
      if (busy !== 1'b0) begin
         fails++; $display("FAIL abort_en_busy: busy got %0b want 0", busy);
      end
      tick(9);
      sig_in = 1'b0;
      tick(5);
      en = 1'b1;
      tick(8);
      checks++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL abort_no_pub: got v=%0b b=%0b want v=0 b=0", valid, busy);
      end
      pulse(5);
      wait_valid("abort_pre_wait");
      sig_in = 1'b1;
      tick(6);
      checks++;
      if (busy !== 1'b1) begin
         fails++; $display("FAIL rst_pre_busy: busy got %0b want 1", busy);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({width, ovf, valid, lost, busy} !== 12'h000) begin
         fails++;
         $display("FAIL rst_mid: got w=%0d o=%0b v=%0b l=%0b b=%0b want all 0",
                  width, ovf, valid, lost, busy);
      end
      sig_in = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(8);
      checks++;
      if (valid !== 1'b0) begin
         fails++; $display("FAIL rst_no_pub: valid got %0b want 0", valid);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_backpressure();
      test_same_edge();
      test_glitch();
      test_startup();
      test_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
